// File: rtl/data_mem_stage.sv
// Data memory pipeline stage: multi-cycle load/store against a small word
// memory, stalling upstream via freeze until the access commits.
// Handshake: a request (mem_r_en | mem_w_en) is accepted in IDLE; upstream
// must hold all inputs stable while freeze=1. In the DONE cycle freeze=0, so
// upstream advances, and any request visible during DONE is ignored.
module data_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 2,
  parameter int DEST_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [DEST_W-1:0] dest,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [DATA_W-1:0] mem_res,
  output logic              freeze,
  output logic              addr_err,
  output logic [1:0]        state_dbg
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [DATA_W-1:0] BASE      = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] DEPTH_LIM = DATA_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]  mem_res_q;
  logic               addr_err_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic [DATA_W-1:0]  offset;
  logic [DATA_W-1:0]  word_off;
  logic [IDX_W-1:0]   idx;
  logic               illegal;
  logic               req;

  // Address decode and legality check, evaluated on the held inputs.
  assign offset   = alu_res - BASE;
  assign word_off = offset >> 2;
  assign idx      = word_off[IDX_W-1:0];
  assign illegal  = (alu_res < BASE) || (word_off >= DEPTH_LIM) ||
                    (alu_res[1:0] != 2'b00);
  assign req      = mem_r_en | mem_w_en;

  // Stall while a request waits in IDLE or the access is in flight.
  assign freeze = (state_q == S_BUSY) || ((state_q == S_IDLE) && req);

  // Pass-through of pipeline control and result with no added latency.
  assign wb_en_out    = wb_en_in;
  assign mem_r_en_out = mem_r_en;
  assign alu_res_out  = alu_res;
  assign dest_out     = dest;

  assign mem_res   = mem_res_q;
  assign addr_err  = addr_err_q;
  assign state_dbg = state_q;

  // Access FSM: counts out the latency, then commits exactly once at the
  // BUSY->DONE edge. Both enables high is treated as a store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_res_q  <= '0;
      addr_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          addr_err_q <= 1'b0;
          if (req) begin
            cnt_q   <= CNT_LOAD;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q    <= S_DONE;
            addr_err_q <= illegal;
            if (illegal) begin
              mem_res_q <= '0;
            end else if (mem_w_en) begin
              mem_q[idx] <= val_rm;
              mem_res_q  <= '0;
            end else begin
              mem_res_q <= mem_q[idx];
            end
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          addr_err_q <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          addr_err_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_stage.sv
// Testbench for data_mem_stage: directed scenarios followed by random
// loads/stores/idle cycles checked against an array-based reference model.
module tb_data_mem_stage;

  localparam int DATA_W  = 32;
  localparam int DEPTH   = 64;
  localparam int BASE    = 1024;
  localparam int LATENCY = 2;
  localparam int DEST_W  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              wb_en_in, mem_r_en, mem_w_en;
  logic [DATA_W-1:0] alu_res, val_rm;
  logic [DEST_W-1:0] dest;
  logic              wb_en_out, mem_r_en_out;
  logic [DATA_W-1:0] alu_res_out, mem_res;
  logic [DEST_W-1:0] dest_out;
  logic              freeze, addr_err;
  logic [1:0]        state_dbg;

  data_mem_stage #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE),
    .LATENCY(LATENCY), .DEST_W(DEST_W)
  ) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en(mem_r_en),
    .mem_w_en(mem_w_en), .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_res_out(alu_res_out), .dest_out(dest_out), .mem_res(mem_res),
    .freeze(freeze), .addr_err(addr_err), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] ref_res;
  logic [DATA_W-1:0] exp_q [$];   // expected mem_res per completed access

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [DATA_W-1:0] a);
    if (a < BASE) return 1'b0;
    if (((a - BASE) / 4) >= DEPTH) return 1'b0;
    if ((a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int word_of(input logic [DATA_W-1:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    ref_res = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit rd, input bit wr, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    mem_r_en = rd;
    mem_w_en = wr;
    alu_res  = a;
    val_rm   = d;
    wb_en_in = rd;
    dest     = DEST_W'($urandom_range(0, 15));
  endtask

  // One full access starting in IDLE. Returns in the DONE cycle (after the
  // negedge sample), leaving the request on the inputs during DONE.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] d);
    int n;
    bit legal;
    logic [DATA_W-1:0] exp_res;
    @(posedge clk); #1;
    drive(rd, wr, a, d);
    n = 0;
    @(negedge clk);
    check({tag, " alu_res_out"}, alu_res_out, a);
    while (freeze && n < 20) begin
      n++;
      @(negedge clk);
    end
    check({tag, " freeze_cycles"}, DATA_W'(n), DATA_W'(LATENCY + 1));
    legal = is_legal(a);
    if (!legal) begin
      ref_res = '0;
    end else if (wr) begin
      ref_mem[word_of(a)] = d;
      ref_res = '0;
    end else begin
      ref_res = ref_mem[word_of(a)];
    end
    exp_q.push_back(ref_res);
    exp_res = exp_q.pop_front();
    check({tag, " mem_res"}, mem_res, exp_res);
    check({tag, " addr_err"}, DATA_W'(addr_err), DATA_W'(!legal));
  endtask

  // A cycle with no memory request: pass-through must be immediate.
  task automatic idle_cycle(input string tag, input bit wb, input logic [DEST_W-1:0] dst,
                            input logic [DATA_W-1:0] a);
    @(posedge clk); #1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    wb_en_in = wb;
    dest     = dst;
    alu_res  = a;
    val_rm   = $urandom;
    #1;
    check({tag, " wb_en_out"}, DATA_W'(wb_en_out), DATA_W'(wb));
    check({tag, " dest_out"}, DATA_W'(dest_out), DATA_W'(dst));
    check({tag, " alu_res_out"}, alu_res_out, a);
    check({tag, " freeze"}, DATA_W'(freeze), '0);
    @(negedge clk);
    check({tag, " mem_res_hold"}, mem_res, ref_res);
    check({tag, " addr_err_low"}, DATA_W'(addr_err), '0);
  endtask

  // Store or load with rst asserted during BUSY cycle k (1 = first BUSY,
  // LATENCY = the commit edge). The access must be aborted.
  task automatic reset_during(input string tag, input bit wr,
                              input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d, input int k);
    @(posedge clk); #1;
    drive(!wr, wr, a, d);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
    rst      = 1'b1;
    mem_r_en = 1'b0;
    mem_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check({tag, " freeze_after_rst"}, DATA_W'(freeze), '0);
    check({tag, " mem_res_after_rst"}, mem_res, '0);
    check({tag, " addr_err_after_rst"}, DATA_W'(addr_err), '0);
  endtask

  function automatic logic [DATA_W-1:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3, 4, 5: return DATA_W'(BASE + 4 * $urandom_range(0, DEPTH - 1));
      6: return DATA_W'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3));
      7: return DATA_W'($urandom_range(0, BASE - 1));
      8: return DATA_W'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 1000));
      default: begin
        case ($urandom_range(0, 2))
          0: return DATA_W'(BASE);
          1: return DATA_W'(BASE + 4 * (DEPTH - 1));
          default: return DATA_W'(BASE + 4 * DEPTH);
        endcase
      end
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    wb_en_in = 1'b0;
    dest = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset mem_res", mem_res, '0);
    check("reset addr_err", DATA_W'(addr_err), '0);
    check("reset freeze", DATA_W'(freeze), '0);

    // Scenario 1: store then load back
    access("s1_store", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    access("s1_load", 1'b1, 1'b0, 32'd1028, 32'h0);
    check("s1 value", mem_res, 32'hDEADBEEF);

    // Scenario 2: illegal addresses, memory untouched
    access("s2_below", 1'b1, 1'b0, 32'd1000, 32'h0);
    access("s2_misal", 1'b1, 1'b0, 32'd1026, 32'h0);
    access("s2_above_st", 1'b0, 1'b1, DATA_W'(BASE + 4 * DEPTH), 32'hFFFF_FFFF);
    access("s2_above_ld", 1'b1, 1'b0, DATA_W'(BASE + 4 * DEPTH), 32'h0);
    access("s2_word0", 1'b1, 1'b0, 32'd1024, 32'h0);
    access("s2_unchanged", 1'b1, 1'b0, 32'd1028, 32'h0);

    // Scenario 3: both enables high acts as a store
    access("s3_both", 1'b1, 1'b1, 32'd1032, 32'd5);
    access("s3_load", 1'b1, 1'b0, 32'd1032, 32'h0);
    check("s3 value", mem_res, 32'd5);

    // Scenario 6: non-memory pass-through
    idle_cycle("s6", 1'b1, 4'd7, 32'd99);

    // Scenario 4: reset in first BUSY cycle aborts the store
    reset_during("s4", 1'b1, 32'd1024, 32'h1234, 1);
    access("s4_load", 1'b1, 1'b0, 32'd1024, 32'h0);
    check("s4 value", mem_res, '0);

    // Reset coinciding with the commit edge of a load
    access("rc_store", 1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D);
    reset_during("rc", 1'b0, 32'd1040, 32'h0, LATENCY);
    access("rc_load", 1'b1, 1'b0, 32'd1040, 32'h0);

    // Scenario 5: back-to-back loads with one DONE cycle between windows
    access("s5_st0", 1'b0, 1'b1, 32'd1024, 32'h1111_2222);
    access("s5_st1", 1'b0, 1'b1, 32'd1028, 32'h3333_4444);
    access("s5_ld0", 1'b1, 1'b0, 32'd1024, 32'h0);
    access("s5_ld1", 1'b1, 1'b0, 32'd1028, 32'h0);

    // Random traffic
    for (int t = 0; t < 300; t++) begin
      case ($urandom_range(0, 3))
        0: access("rnd_load", 1'b1, 1'b0, rand_addr(), 32'h0);
        1: access("rnd_store", 1'b0, 1'b1, rand_addr(), $urandom);
        2: access("rnd_both", 1'b1, 1'b1, rand_addr(), $urandom);
        default: idle_cycle("rnd_idle", 1'($urandom_range(0, 1)),
                            DEST_W'($urandom_range(0, 15)), $urandom);
      endcase
    end

    // Final sweep: every word read back against the model
    for (int i = 0; i < DEPTH; i++) begin
      access("sweep", 1'b1, 1'b0, DATA_W'(BASE + 4 * i), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
